// File: rtl/branch_ctrl_pkg.sv
// Shared opcode constants, widths and FSM state type for the branch-control stage.
package branch_ctrl_pkg;

  localparam int unsigned BAMT_W = 15;
  localparam int unsigned OP_W   = 5;

  typedef logic [OP_W-1:0] op_t;

  localparam op_t NOP = 5'h00;
  localparam op_t BA  = 5'h10;
  localparam op_t BL  = 5'h11;
  localparam op_t BG  = 5'h12;
  localparam op_t BE  = 5'h13;

  typedef enum logic {
    ST_LOAD,
    ST_RUN
  } state_t;

  function automatic logic is_branch(input op_t op);
    return (op == BA) || (op == BL) || (op == BG) || (op == BE);
  endfunction

endpackage

// File: rtl/branch_ctrl_if.sv
// LUT load port: valid/ready beats carrying an entry index, offset and last marker.
interface branch_ctrl_if
  import branch_ctrl_pkg::*;
#(
  parameter int unsigned IDX_W = 4
);
  logic              ld_valid;
  logic              ld_ready;
  logic [IDX_W-1:0]  ld_idx;
  logic [BAMT_W-1:0] ld_data;
  logic              ld_last;

  modport master (output ld_valid, ld_idx, ld_data, ld_last, input ld_ready);
  modport slave  (input ld_valid, ld_idx, ld_data, ld_last, output ld_ready);
endinterface

// File: rtl/branch_ctrl_lut.sv
// Branch-offset register file: one write port, one asynchronous read port and a
// per-entry written mask, all cleared by reset.
module branch_lut #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned IDX_W = 4,
  parameter int unsigned W     = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_waddr,
  input  logic [W-1:0]     i_wdata,
  input  logic [IDX_W-1:0] i_raddr,
  output logic [W-1:0]     o_rdata,
  output logic             o_rvalid
);

  logic [W-1:0]     r_mem [DEPTH];
  logic [DEPTH-1:0] r_mask;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem  <= '{default: '0};
      r_mask <= '0;
    end else if (i_we) begin
      r_mem[i_waddr]  <= i_wdata;
      r_mask[i_waddr] <= 1'b1;
    end
  end

  assign o_rdata  = r_mem[i_raddr];
  assign o_rvalid = r_mask[i_raddr];

endmodule

// File: rtl/branch_ctrl.sv
// Branch-control stage ahead of the PC: LUT load FSM, compare flags, saturating
// branch counter and op/bamt muxing into the PC.
module branch_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int unsigned LUT_DEPTH = 16,
  parameter int unsigned IDX_W     = $clog2(LUT_DEPTH),
  parameter int unsigned CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [OP_W-1:0]   instr_op,
  input  logic [IDX_W-1:0]  instr_idx,
  input  logic              flag_we,
  input  logic              alu_z,
  input  logic              alu_lt,
  branch_ctrl_if.slave      ld,
  input  logic              reload,
  output logic [OP_W-1:0]   op,
  output logic              z,
  output logic              lt,
  output logic [BAMT_W-1:0] bamt,
  output logic              run,
  output logic              lut_err,
  output logic [CNT_W-1:0]  branch_cnt
);

  state_t             r_state;
  state_t             w_next_state;
  logic               r_z;
  logic               r_lt;
  logic               r_err;
  logic [CNT_W-1:0]   r_cnt;
  logic               w_ld_fire;
  logic               w_idx_oob;
  logic               w_lut_we;
  logic               w_is_br;
  logic [BAMT_W-1:0]  w_rd_data;
  logic               w_rd_valid;

  // Out-of-range load indices are only reachable for non-power-of-two depths.
  if (LUT_DEPTH < (1 << IDX_W)) begin : g_oob
    assign w_idx_oob = (32'(ld.ld_idx) >= LUT_DEPTH);
  end else begin : g_no_oob
    assign w_idx_oob = 1'b0;
  end

  assign w_ld_fire = ld.ld_valid && (r_state == ST_LOAD);
  assign w_lut_we  = w_ld_fire && !w_idx_oob;
  assign w_is_br   = (r_state == ST_RUN) && is_branch(instr_op);

  branch_lut #(
    .DEPTH (LUT_DEPTH),
    .IDX_W (IDX_W),
    .W     (BAMT_W)
  ) u_lut (
    .clk      (clk),
    .rst      (reset),
    .i_we     (w_lut_we),
    .i_waddr  (ld.ld_idx),
    .i_wdata  (ld.ld_data),
    .i_raddr  (instr_idx),
    .o_rdata  (w_rd_data),
    .o_rvalid (w_rd_valid)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_LOAD;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_LOAD: if (w_ld_fire && ld.ld_last) w_next_state = ST_RUN;
      ST_RUN:  if (reload)                  w_next_state = ST_LOAD;
      default: w_next_state = ST_LOAD;
    endcase
  end

  // Unloaded branch targets fall through with an offset of 1.
  always_comb begin
    ld.ld_ready = (r_state == ST_LOAD);
    op          = NOP;
    bamt        = '0;
    if (r_state == ST_RUN) begin
      op = instr_op;
      if (is_branch(instr_op)) bamt = w_rd_valid ? w_rd_data : BAMT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_z   <= 1'b0;
      r_lt  <= 1'b0;
      r_err <= 1'b0;
      r_cnt <= '0;
    end else begin
      if ((r_state == ST_RUN) && flag_we) begin
        r_z  <= alu_z;
        r_lt <= alu_lt;
      end
      if ((w_ld_fire && w_idx_oob) || (w_is_br && !w_rd_valid)) r_err <= 1'b1;
      if (w_is_br && (r_cnt != '1)) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign z          = r_z;
  assign lt         = r_lt;
  assign run        = (r_state == ST_RUN);
  assign lut_err    = r_err;
  assign branch_cnt = r_cnt;

endmodule

// File: doc/branch_ctrl.md
Name: branch_ctrl

Overview:
- Branch-control stage directly upstream of the program counter.
- Holds a 16-entry branch-offset lookup table (LUT), loaded over a valid/ready port after reset.
- Holds the compare flags z/lt written from the ALU.
- Drives op, z, lt and bamt into the PC each cycle, and raises run so the top level releases the PC from reset only once the LUT is loaded.

Parameters:
- LUT_DEPTH, 16, number of branch-offset entries.
- IDX_W, 4, LUT index width, equal to clog2(LUT_DEPTH).
- BAMT_W, 15, branch offset width, matching the PC bamt input.
- OP_W, 5, opcode width, matching the PC op input.
- CNT_W, 16, branch counter width.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- instr_op  in  OP_W  opcode of the current instruction.
- instr_idx  in  IDX_W  LUT index field of the current instruction.
- flag_we  in  1  current instruction is a compare; latch ALU flags.
- alu_z  in  1  ALU zero result.
- alu_lt  in  1  ALU less-than result.
- ld_valid  in  1  LUT load beat valid.
- ld_ready  out  1  LUT load beat accepted.
- ld_idx  in  IDX_W  LUT entry to write.
- ld_data  in  BAMT_W  offset value to write.
- ld_last  in  1  final load beat.
- reload  in  1  single-cycle pulse; return to LOAD from RUN.
- op  out  OP_W  opcode to the PC.
- z  out  1  registered zero flag to the PC.
- lt  out  1  registered less-than flag to the PC.
- bamt  out  BAMT_W  branch offset to the PC.
- run  out  1  registered; 1 in RUN state.
- lut_err  out  1  sticky error flag.
- branch_cnt  out  CNT_W  count of branch ops issued in RUN; saturating.

Behaviour:
- Clock, reset and state:
  - Single clock clk. Reset is asynchronous and active-high, on port reset.
  - Two states: LOAD and RUN.
- Reset values, forced immediately on reset assertion:
  - State LOAD.
  - z=0, lt=0, run=0, lut_err=0, branch_cnt=0.
  - All LUT entries 0; written-mask all 0.
- LOAD state:
  - ld_ready=1, combinational from state.
  - A beat transfers when ld_valid && ld_ready: entry[ld_idx] <= ld_data and mask[ld_idx] <= 1 at the next edge.
  - Rewriting an already-written entry overwrites it, with no error.
  - ld_idx >= LUT_DEPTH: write is ignored and lut_err is set. This can only occur when LUT_DEPTH is not a power of two.
  - A transfer carrying ld_last moves the state to RUN at that edge. run reads 1 from the following cycle.
  - Outputs op=NOP and bamt=0, regardless of instr_op.
  - Flags are held; flag_we is ignored.
- RUN state:
  - ld_ready=0; ld_valid is ignored.
  - op = instr_op, combinational, with zero latency.
  - bamt, combinational:
    - instr_op in {BA, BL, BG, BE} and mask[instr_idx]=1: bamt = entry[instr_idx].
    - Branch op and mask[instr_idx]=0: bamt = 1, so the branch falls through safely, and lut_err is set at the next edge.
    - Any non-branch op: bamt = 0.
  - Flags:
    - When flag_we=1, z <= alu_z and lt <= alu_lt at the edge; the new values are visible the next cycle.
    - If a branch and flag_we occur in the same cycle, the branch sees the old flags.
  - branch_cnt increments by 1 on every cycle where op is a branch op. It saturates at 2^CNT_W-1 with no wrap.
- reload:
  - In RUN, reload moves the state to LOAD at the next edge and run falls.
  - LUT entries, mask, flags and branch_cnt are retained; later writes overwrite.
  - reload is ignored in LOAD.
- lut_err is sticky and is cleared only by reset.
- Asserting reset during LOAD or RUN, including mid-load, discards all LUT contents and restarts in LOAD.
- Width rules:
  - bamt is passed through unmodified. Sign interpretation and PC wrap belong to the PC.
  - The branch_cnt increment is an unsigned CNT_W-bit add with a saturation compare.

Decomposition:
- Shared definitions package:
  - Opcode constants BA, BL, BG, BE, NOP; add NOP if it is not already present.
  - BAMT_W and OP_W.
  - A function is_branch(op).
- One sub-module, branch_lut:
  - Register file of LUT_DEPTH x BAMT_W.
  - One write port and one asynchronous read port.
  - Per-entry valid mask, cleared on reset.
- branch_ctrl holds the FSM, flags, counter and output muxing.

Test Plan:
- Reset, then load idx0=5, idx1=0x7FFD, then idx2=3 with ld_last.
  - ld_ready=1 for 3 beats, then run=1 one cycle after the last beat.
  - In RUN, instr_op=BA, idx=1 gives op=BA and bamt=0x7FFD.
- In RUN, drive flag_we=1, alu_lt=1 alongside instr_op=BL.
  - Same cycle: lt=0 and bamt is the LUT value.
  - Next cycle: lt=1.
- In RUN, instr_op=BE with idx=9 (never loaded).
  - Same cycle: bamt=1.
  - Next cycle: lut_err=1, which stays 1 through a reload.
- During LOAD, with instr_op=BA driven, op=NOP and bamt=0.
- Assert reset mid-load after 2 beats.
  - All outputs return to reset values immediately, without a clock edge.
  - After reload, reading idx0 gives fall-through bamt=1.
- Preload branch_cnt to 0xFFFE by issuing 65534 branches, then issue 3 more: branch_cnt=0xFFFF and it holds.
